address_gen_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/index_adder.sv | 18 +
 rtl/address_gen_unit.sv | 170 +++++++++++++++++
 tb/tb_address_gen_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 address path: addressing-mode codes,
// vector selects, address-generator FSM states and parameter defaults.
package cpu_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int PAGE_W_DEF      = 8;
  localparam int STACK_PAGE_DEF  = 1;
  localparam int FIX_PENALTY_DEF = 1;

  localparam logic [3:0] AM_PC      = 4'd0;
  localparam logic [3:0] AM_ZP      = 4'd1;
  localparam logic [3:0] AM_ABS     = 4'd2;
  localparam logic [3:0] AM_PTR_LO  = 4'd3;
  localparam logic [3:0] AM_PTR_HI  = 4'd4;
  localparam logic [3:0] AM_IND     = 4'd5;
  localparam logic [3:0] AM_IND_INC = 4'd6;
  localparam logic [3:0] AM_STACK   = 4'd7;
  localparam logic [3:0] AM_ZP_IDX  = 4'd8;
  localparam logic [3:0] AM_ABS_IDX = 4'd9;
  localparam logic [3:0] AM_IND_IDX = 4'd10;
  localparam logic [3:0] AM_VECTOR  = 4'd11;

  localparam logic [1:0] VEC_NMI   = 2'd0;
  localparam logic [1:0] VEC_RESET = 2'd1;
  localparam logic [1:0] VEC_IRQ   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIX,
    ST_VEC_LO,
    ST_VEC_HI
  } agu_state_t;

  // Distance of each vector's low byte below the top of the address space;
  // the reserved select falls through to IRQ.
  function automatic int unsigned vec_offset(input logic [1:0] sel);
    case (sel)
      VEC_NMI:   vec_offset = 5;
      VEC_RESET: vec_offset = 3;
      default:   vec_offset = 1;
    endcase
  endfunction

endpackage

// File: rtl/index_adder.sv
// Low-byte adder with carry-out plus a high-part incrementer; the caller
// decides whether and when to apply the incremented high part.
module index_adder #(
  parameter int PAGE_W = 8,
  parameter int HI_W   = 8
) (
  input  logic [PAGE_W-1:0] base_lo,
  input  logic [HI_W-1:0]   base_hi,
  input  logic [PAGE_W-1:0] index,
  output logic [PAGE_W-1:0] sum_lo,
  output logic              carry,
  output logic [HI_W-1:0]   hi_inc
);

  assign {carry, sum_lo} = {1'b0, base_lo} + {1'b0, index};
  assign hi_inc          = base_hi + HI_W'(1);

endmodule

// File: rtl/address_gen_unit.sv
// Registered 6502 address generator: direct/indexed modes with optional
// page-cross fix-up cycle, and a two-cycle interrupt/reset vector fetch.
module address_gen_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                PAGE_W      = PAGE_W_DEF,
  parameter int                STACK_PAGE  = STACK_PAGE_DEF,
  parameter logic [ADDR_W-1:0] VEC_TOP     = '1,
  parameter int                FIX_PENALTY = FIX_PENALTY_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               mode,
  input  logic [1:0]               vec_sel,
  input  logic [PAGE_W-1:0]        pcl,
  input  logic [ADDR_W-PAGE_W-1:0] pch,
  input  logic [PAGE_W-1:0]        sp,
  input  logic [PAGE_W-1:0]        dirl,
  input  logic [ADDR_W-PAGE_W-1:0] dirh,
  input  logic [PAGE_W-1:0]        indirl,
  input  logic [ADDR_W-PAGE_W-1:0] indirh,
  input  logic [PAGE_W-1:0]        index,
  output logic [ADDR_W-1:0]        addr,
  output logic                     addr_valid,
  output logic                     page_cross,
  output logic                     busy,
  output logic                     vec_phase
);

  localparam int HI_W = ADDR_W - PAGE_W;
  localparam logic [ADDR_W-1:0] RESET_VEC_LO = VEC_TOP - ADDR_W'(3);

  agu_state_t        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              addr_valid_reg;
  logic              page_cross_reg;
  logic              busy_reg;
  logic              vec_phase_reg;
  logic [HI_W-1:0]   fix_hi_reg;

  logic [PAGE_W-1:0] idx_base_lo;
  logic [HI_W-1:0]   idx_base_hi;
  logic [PAGE_W-1:0] idx_sum_lo;
  logic              idx_carry;
  logic [HI_W-1:0]   idx_hi_inc;
  logic [PAGE_W-1:0] inc_sum_lo;
  logic              inc_carry;
  logic [HI_W-1:0]   inc_hi_inc;
  logic [ADDR_W-1:0] idx_full;
  logic [ADDR_W-1:0] vec_addr;
  logic [ADDR_W-1:0] direct_addr;
  logic              is_abs_indexed;

  assign is_abs_indexed = (mode == AM_ABS_IDX) || (mode == AM_IND_IDX);
  assign idx_base_lo    = (mode == AM_IND_IDX) ? indirl : dirl;
  assign idx_base_hi    = (mode == AM_IND_IDX) ? indirh : dirh;

  index_adder #(.PAGE_W(PAGE_W), .HI_W(HI_W)) u_idx_adder (
    .base_lo (idx_base_lo),
    .base_hi (idx_base_hi),
    .index   (index),
    .sum_lo  (idx_sum_lo),
    .carry   (idx_carry),
    .hi_inc  (idx_hi_inc)
  );

  // Pointer increment: low byte alone serves PTR_HI (page-0 wrap),
  // with carry it serves the full-width IND+1.
  index_adder #(.PAGE_W(PAGE_W), .HI_W(HI_W)) u_ptr_inc (
    .base_lo (indirl),
    .base_hi (indirh),
    .index   (PAGE_W'(1)),
    .sum_lo  (inc_sum_lo),
    .carry   (inc_carry),
    .hi_inc  (inc_hi_inc)
  );

  assign idx_full = idx_carry ? {idx_hi_inc, idx_sum_lo} : {idx_base_hi, idx_sum_lo};
  assign vec_addr = VEC_TOP - ADDR_W'(vec_offset(vec_sel));

  always_comb begin
    direct_addr = {pch, pcl};
    case (mode)
      AM_ZP:      direct_addr = {HI_W'(0), dirl};
      AM_ABS:     direct_addr = {dirh, dirl};
      AM_PTR_LO:  direct_addr = {HI_W'(0), indirl};
      AM_PTR_HI:  direct_addr = {HI_W'(0), inc_sum_lo};
      AM_IND:     direct_addr = {indirh, indirl};
      AM_IND_INC: direct_addr = inc_carry ? {inc_hi_inc, inc_sum_lo} : {indirh, inc_sum_lo};
      AM_STACK:   direct_addr = {HI_W'(STACK_PAGE), sp};
      AM_ZP_IDX:  direct_addr = {HI_W'(0), idx_sum_lo};
      AM_ABS_IDX: direct_addr = idx_full;
      AM_IND_IDX: direct_addr = idx_full;
      default:    direct_addr = {pch, pcl};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= RESET_VEC_LO;
      addr_valid_reg <= 1'b0;
      page_cross_reg <= 1'b0;
      busy_reg       <= 1'b0;
      vec_phase_reg  <= 1'b0;
      fix_hi_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          addr_valid_reg <= 1'b0;
          page_cross_reg <= 1'b0;
          busy_reg       <= 1'b0;
          vec_phase_reg  <= 1'b0;
          if (start) begin
            if (mode == AM_VECTOR) begin
              addr_reg       <= vec_addr;
              addr_valid_reg <= 1'b1;
              busy_reg       <= 1'b1;
              state_reg      <= ST_VEC_LO;
            end else if (is_abs_indexed && idx_carry) begin
              page_cross_reg <= 1'b1;
              if (FIX_PENALTY != 0) begin
                // Dummy read at the un-carried address, high part applied next cycle.
                addr_reg   <= {idx_base_hi, idx_sum_lo};
                fix_hi_reg <= idx_hi_inc;
                busy_reg   <= 1'b1;
                state_reg  <= ST_FIX;
              end else begin
                addr_reg       <= idx_full;
                addr_valid_reg <= 1'b1;
              end
            end else begin
              addr_reg       <= direct_addr;
              addr_valid_reg <= 1'b1;
            end
          end
        end
        ST_FIX: begin
          addr_reg       <= {fix_hi_reg, addr_reg[PAGE_W-1:0]};
          addr_valid_reg <= 1'b1;
          page_cross_reg <= 1'b0;
          busy_reg       <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        ST_VEC_LO: begin
          addr_reg       <= addr_reg + ADDR_W'(1);
          addr_valid_reg <= 1'b1;
          vec_phase_reg  <= 1'b1;
          state_reg      <= ST_VEC_HI;
        end
        ST_VEC_HI: begin
          addr_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
          vec_phase_reg  <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign addr       = addr_reg;
  assign addr_valid = addr_valid_reg;
  assign page_cross = page_cross_reg;
  assign busy       = busy_reg;
  assign vec_phase  = vec_phase_reg;

endmodule

// File: tb/tb_address_gen_unit.sv
// Directed bench for address_gen_unit: a vector table of single-cycle modes
// on both fix-up variants, plus page-cross, vector and reset sequences.
module tb_address_gen_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mode;
  logic [1:0] vec_sel;
  logic [7:0] pcl, pch, sp, dirl, dirh, indirl, indirh, index;

  logic [15:0] addr0, addr1;
  logic        valid0, valid1, pc0, pc1, busy0, busy1, vph0, vph1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  address_gen_unit #(.FIX_PENALTY(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_sel(vec_sel),
    .pcl(pcl), .pch(pch), .sp(sp), .dirl(dirl), .dirh(dirh),
    .indirl(indirl), .indirh(indirh), .index(index),
    .addr(addr0), .addr_valid(valid0), .page_cross(pc0), .busy(busy0), .vec_phase(vph0)
  );

  address_gen_unit #(.FIX_PENALTY(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_sel(vec_sel),
    .pcl(pcl), .pch(pch), .sp(sp), .dirl(dirl), .dirh(dirh),
    .indirl(indirl), .indirh(indirh), .index(index),
    .addr(addr1), .addr_valid(valid1), .page_cross(pc1), .busy(busy1), .vec_phase(vph1)
  );

  typedef struct {
    string       name;
    logic [3:0]  mode;
    logic [15:0] pc;
    logic [15:0] dir;
    logic [15:0] ind;
    logic [7:0]  sp;
    logic [7:0]  idx;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [3:0] m, input logic [15:0] pc, input logic [15:0] dir,
                         input logic [15:0] ind, input logic [7:0] s, input logic [7:0] idx);
    mode = m;
    {pch, pcl} = pc;
    {dirh, dirl} = dir;
    {indirh, indirl} = ind;
    sp = s;
    index = idx;
  endtask

  initial begin
    tbl[0]  = '{"pc",       4'd0,  16'h3456, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h3456};
    tbl[1]  = '{"zp",       4'd1,  16'h0000, 16'h9942, 16'h0000, 8'h00, 8'h00, 16'h0042};
    tbl[2]  = '{"abs",      4'd2,  16'h0000, 16'h1234, 16'h0000, 8'h00, 8'h00, 16'h1234};
    tbl[3]  = '{"ptr_lo",   4'd3,  16'h0000, 16'h0000, 16'h5580, 8'h00, 8'h00, 16'h0080};
    tbl[4]  = '{"ptr_hi",   4'd4,  16'h0000, 16'h0000, 16'h55FF, 8'h00, 8'h00, 16'h0000};
    tbl[5]  = '{"ind",      4'd5,  16'h0000, 16'h0000, 16'hABCD, 8'h00, 8'h00, 16'hABCD};
    tbl[6]  = '{"ind_inc",  4'd6,  16'h0000, 16'h0000, 16'h12FF, 8'h00, 8'h00, 16'h1300};
    tbl[7]  = '{"stack",    4'd7,  16'h0000, 16'h0000, 16'h0000, 8'hFD, 8'h00, 16'h01FD};
    tbl[8]  = '{"zp_idx",   4'd8,  16'h0000, 16'h77F0, 16'h0000, 8'h00, 8'h20, 16'h0010};
    tbl[9]  = '{"abs_idx",  4'd9,  16'h0000, 16'h1210, 16'h0000, 8'h00, 8'h05, 16'h1215};
    tbl[10] = '{"ind_idx",  4'd10, 16'h0000, 16'h0000, 16'h2000, 8'h00, 8'h10, 16'h2010};
    tbl[11] = '{"mode13",   4'd13, 16'hBEEF, 16'h1111, 16'h2222, 8'h00, 8'h00, 16'hBEEF};

    rst = 1'b1; start = 1'b0; vec_sel = 2'd0;
    set_ops(4'd0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0);

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    check("rst_addr", addr0, 16'hFFFC);
    check("rst_busy", busy0, 0);
    check("rst_valid", valid0, 0);
    check("rst_pc", pc0, 0);
    check("rst_vph", vph0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-cycle table
    for (int i = 0; i < 12; i++) begin
      set_ops(tbl[i].mode, tbl[i].pc, tbl[i].dir, tbl[i].ind, tbl[i].sp, tbl[i].idx);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      $display("vec %0d %s addr0=%04h addr1=%04h exp=%04h", i, tbl[i].name, addr0, addr1, tbl[i].exp_addr);
      check({tbl[i].name, "_addr"}, addr0, tbl[i].exp_addr);
      check({tbl[i].name, "_valid"}, valid0, 1);
      check({tbl[i].name, "_busy"}, busy0, 0);
      check({tbl[i].name, "_pc"}, pc0, 0);
      check({tbl[i].name, "_addr_nofix"}, addr1, tbl[i].exp_addr);
    end

    // Idle hold: no start -> address held, not valid
    @(negedge clk);
    check("idle_addr", addr0, 16'hBEEF);
    check("idle_valid", valid0, 0);

    // ABS_IDX page cross; start during FIX must be ignored
    set_ops(4'd9, 16'h0, 16'h12F0, 16'h0, 8'h0, 8'h20);
    start = 1'b1;
    @(negedge clk);
    $display("abs_idx cross c1 addr0=%04h pc0=%0b addr1=%04h pc1=%0b", addr0, pc0, addr1, pc1);
    check("absx_c1_addr", addr0, 16'h1210);
    check("absx_c1_pc", pc0, 1);
    check("absx_c1_valid", valid0, 0);
    check("absx_c1_busy", busy0, 1);
    check("absx_nofix_addr", addr1, 16'h1310);
    check("absx_nofix_pc", pc1, 1);
    check("absx_nofix_valid", valid1, 1);
    check("absx_nofix_busy", busy1, 0);
    set_ops(4'd2, 16'h0, 16'h4444, 16'h0, 8'h0, 8'h00);
    @(negedge clk);
    start = 1'b0;
    $display("abs_idx cross c2 addr0=%04h valid0=%0b", addr0, valid0);
    check("absx_c2_addr", addr0, 16'h1310);
    check("absx_c2_valid", valid0, 1);
    check("absx_c2_pc", pc0, 0);
    check("absx_c2_busy", busy0, 0);

    // IND_IDX wrap at top of address space
    @(negedge clk);
    set_ops(4'd10, 16'h0, 16'h0, 16'hFFFF, 8'h0, 8'h01);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("ind_idx wrap c1 addr0=%04h addr1=%04h", addr0, addr1);
    check("indx_c1_addr", addr0, 16'hFF00);
    check("indx_c1_pc", pc0, 1);
    check("indx_nofix_addr", addr1, 16'h0000);
    @(negedge clk);
    $display("ind_idx wrap c2 addr0=%04h", addr0);
    check("indx_c2_addr", addr0, 16'h0000);
    check("indx_c2_valid", valid0, 1);

    // NMI vector with start held high throughout
    @(negedge clk);
    set_ops(4'd11, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0);
    vec_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    set_ops(4'd2, 16'h0, 16'h5555, 16'h0, 8'h0, 8'h0);
    $display("nmi c1 addr0=%04h vph=%0b busy=%0b", addr0, vph0, busy0);
    check("nmi_c1_addr", addr0, 16'hFFFA);
    check("nmi_c1_vph", vph0, 0);
    check("nmi_c1_busy", busy0, 1);
    check("nmi_c1_valid", valid0, 1);
    @(negedge clk);
    $display("nmi c2 addr0=%04h vph=%0b busy=%0b", addr0, vph0, busy0);
    check("nmi_c2_addr", addr0, 16'hFFFB);
    check("nmi_c2_vph", vph0, 1);
    check("nmi_c2_busy", busy0, 1);
    @(negedge clk);
    start = 1'b0;
    $display("nmi c3 addr0=%04h busy=%0b", addr0, busy0);
    check("nmi_c3_busy", busy0, 0);
    check("nmi_c3_addr", addr0, 16'hFFFB);

    // IRQ vector
    @(negedge clk);
    set_ops(4'd11, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0);
    vec_sel = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("irq_c1_addr", addr0, 16'hFFFE);
    @(negedge clk);
    check("irq_c2_addr", addr0, 16'hFFFF);
    check("irq_c2_vph", vph0, 1);
    @(negedge clk);

    // Reset during VEC_LO aborts the sequence
    vec_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rstv_c1_addr", addr0, 16'hFFFA);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset in vec_lo addr0=%04h busy=%0b", addr0, busy0);
    check("rstv_addr", addr0, 16'hFFFC);
    check("rstv_busy", busy0, 0);
    check("rstv_vph", vph0, 0);
    check("rstv_valid", valid0, 0);
    set_ops(4'd1, 16'h0, 16'h0042, 16'h0, 8'h0, 8'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_addr", addr0, 16'h0042);
    check("post_rst_valid", valid0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
